load_store_unit: RTL and testbench

Initiator-side load/store unit for the multicycle RISC-V core. It accepts one load or store request at a time from the execute stage, using the existing 3-bit DMCtrl width encoding. It issues one or two word-aligned accesses to a synchronous, byte-enabled data memory with fixed one-cycle read latency. Misaligned halfword and word accesses that cross a word boundary are split transparently. Load data is merged, extended and returned to the core.

---
 rtl/lsu_pkg.sv | 38 +++
 rtl/lsu_align.sv | 53 +++++
 rtl/load_store_unit.sv | 166 ++++++++++++++++
 tb/tb_load_store_unit.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: DMCtrl width encodings,
// FSM state type and request decode helpers.
package lsu_pkg;

   localparam logic [2:0] CTRL_B  = 3'b000;
   localparam logic [2:0] CTRL_H  = 3'b001;
   localparam logic [2:0] CTRL_W  = 3'b010;
   localparam logic [2:0] CTRL_BU = 3'b100;
   localparam logic [2:0] CTRL_HU = 3'b101;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE0,
      ST_ISSUE1,
      ST_CAPT,
      ST_RESP
   } lsu_state_t;

   // Access size in bytes; 0 for encodings with no defined width.
   function automatic logic [2:0] ctrl_size(input logic [2:0] ctrl);
      case (ctrl)
         CTRL_B, CTRL_BU: ctrl_size = 3'd1;
         CTRL_H, CTRL_HU: ctrl_size = 3'd2;
         CTRL_W:          ctrl_size = 3'd4;
         default:         ctrl_size = 3'd0;
      endcase
   endfunction

   // Unsigned widths only make sense for loads.
   function automatic logic ctrl_legal(input logic [2:0] ctrl, input logic we);
      case (ctrl)
         CTRL_B, CTRL_H, CTRL_W: ctrl_legal = 1'b1;
         CTRL_BU, CTRL_HU:       ctrl_legal = ~we;
         default:                ctrl_legal = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane alignment: byte enables and write data across the two
// words of a possibly split access, plus load merge and extension.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [1:0]  i_offset,
   input  logic [2:0]  i_ctrl,
   input  logic [31:0] i_wdata,
   input  logic [31:0] i_word0,
   input  logic [31:0] i_word1,
   output logic        o_split,
   output logic [7:0]  o_be,
   output logic [63:0] o_wdata,
   output logic [31:0] o_rdata
);

   logic [2:0]  w_size;
   logic [3:0]  w_mask;
   logic [5:0]  w_shamt;
   logic [63:0] w_wshift;
   logic [31:0] w_rshift;

   always_comb begin
      w_size   = ctrl_size(i_ctrl);
      w_shamt  = {i_offset, 3'b000};
      case (w_size)
         3'd1:    w_mask = 4'b0001;
         3'd2:    w_mask = 4'b0011;
         3'd4:    w_mask = 4'b1111;
         default: w_mask = 4'b0000;
      endcase
      o_split  = ({1'b0, i_offset} + w_size) > 3'd4;
      o_be     = 8'({4'b0000, w_mask} << i_offset);
      w_wshift = {32'h0000_0000, i_wdata} << w_shamt;

      // Upper bytes of right-aligned store data must not leak into idle lanes.
      o_wdata = '0;
      for (int unsigned i = 0; i < 8; i++) begin
         if (o_be[i]) o_wdata[8*i +: 8] = w_wshift[8*i +: 8];
      end

      w_rshift = 32'({i_word1, i_word0} >> w_shamt);
      case (i_ctrl)
         CTRL_B:  o_rdata = {{24{w_rshift[7]}}, w_rshift[7:0]};
         CTRL_H:  o_rdata = {{16{w_rshift[15]}}, w_rshift[15:0]};
         CTRL_W:  o_rdata = w_rshift;
         CTRL_BU: o_rdata = {24'h000000, w_rshift[7:0]};
         CTRL_HU: o_rdata = {16'h0000, w_rshift[15:0]};
         default: o_rdata = '0;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one request, issues one or two word accesses to a
// one-cycle-latency data memory, and returns the merged, extended result.
module load_store_unit
   import lsu_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_ctrl,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   lsu_state_t  r_state;
   lsu_state_t  w_next;

   logic        r_we;
   logic        r_err;
   logic [2:0]  r_ctrl;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [31:0] r_word0;

   logic        r_mem_req;
   logic        r_mem_we;
   logic [31:0] r_mem_addr;
   logic [3:0]  r_mem_be;
   logic [31:0] r_mem_wdata;
   logic        r_rsp_valid;
   logic [31:0] r_rsp_rdata;
   logic        r_rsp_err;

   logic        w_idle;
   logic        w_accept;
   logic        w_legal;
   logic [1:0]  w_offset;
   logic [2:0]  w_ctrl;
   logic [31:0] w_wdata_in;
   logic [31:0] w_word0;
   logic        w_split;
   logic [7:0]  w_be;
   logic [63:0] w_wdata;
   logic [31:0] w_rdata;

   assign w_idle   = (r_state == ST_IDLE);
   assign w_accept = req_valid && w_idle;
   assign w_legal  = ctrl_legal(req_ctrl, req_we);

   // In IDLE the aligner sees the live request so word 0 can be registered on accept.
   assign w_offset   = w_idle ? req_addr[1:0] : r_addr[1:0];
   assign w_ctrl     = w_idle ? req_ctrl      : r_ctrl;
   assign w_wdata_in = w_idle ? req_wdata     : r_wdata;
   assign w_word0    = w_split ? r_word0 : mem_rdata;

   lsu_align u_align (
      .i_offset (w_offset),
      .i_ctrl   (w_ctrl),
      .i_wdata  (w_wdata_in),
      .i_word0  (w_word0),
      .i_word1  (mem_rdata),
      .o_split  (w_split),
      .o_be     (w_be),
      .o_wdata  (w_wdata),
      .o_rdata  (w_rdata)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_next;
   end

   // Illegal requests pass through CAPT so the error response lands two cycles after accept.
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:   if (w_accept) w_next = w_legal ? ST_ISSUE0 : ST_CAPT;
         ST_ISSUE0: w_next = w_split ? ST_ISSUE1 : ST_CAPT;
         ST_ISSUE1: w_next = ST_CAPT;
         ST_CAPT:   w_next = ST_RESP;
         ST_RESP:   w_next = ST_IDLE;
         default:   w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_we        <= 1'b0;
         r_err       <= 1'b0;
         r_ctrl      <= '0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_word0     <= '0;
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_be    <= '0;
         r_mem_wdata <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= '0;
         r_rsp_err   <= 1'b0;
      end else begin
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_be    <= '0;
         r_mem_wdata <= '0;
         r_rsp_valid <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_we    <= req_we;
                  r_err   <= ~w_legal;
                  r_ctrl  <= req_ctrl;
                  r_addr  <= req_addr;
                  r_wdata <= req_wdata;
                  if (w_legal) begin
                     r_mem_req   <= 1'b1;
                     r_mem_we    <= req_we;
                     r_mem_addr  <= {req_addr[31:2], 2'b00};
                     r_mem_be    <= w_be[3:0];
                     r_mem_wdata <= w_wdata[31:0];
                  end
               end
            end
            ST_ISSUE0: begin
               if (w_split) begin
                  r_mem_req   <= 1'b1;
                  r_mem_we    <= r_we;
                  r_mem_addr  <= {r_addr[31:2], 2'b00} + 32'd4;
                  r_mem_be    <= w_be[7:4];
                  r_mem_wdata <= w_wdata[63:32];
               end
            end
            ST_ISSUE1: r_word0 <= mem_rdata;
            ST_CAPT: begin
               r_rsp_valid <= 1'b1;
               r_rsp_err   <= r_err;
               r_rsp_rdata <= (r_err || r_we) ? '0 : w_rdata;
            end
            default: ;
         endcase
      end
   end

   assign req_ready = w_idle;
   assign rsp_valid = r_rsp_valid;
   assign rsp_rdata = r_rsp_rdata;
   assign rsp_err   = r_rsp_err;
   assign mem_req   = r_mem_req;
   assign mem_we    = r_mem_we;
   assign mem_addr  = r_mem_addr;
   assign mem_be    = r_mem_be;
   assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: byte-level memory and reference
// model, directed cases followed by randomized requests.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_ctrl;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata = '0;

   int    checks = 0;
   int    errors = 0;
   string cur_name = "init";

   logic [7:0] bmem    [logic [31:0]];
   logic [7:0] ref_mem [logic [31:0]];

   always #5 clk = ~clk;

   load_store_unit dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_ctrl  (req_ctrl),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_be    (mem_be),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   function automatic logic [31:0] bmem_word(input logic [31:0] a);
      logic [31:0] w;
      logic [31:0] k;
      w = '0;
      for (int b = 0; b < 4; b++) begin
         k = a + 32'(b);
         if (bmem.exists(k)) w[8*b +: 8] = bmem[k];
      end
      return w;
   endfunction

   // Synchronous byte-enabled memory, one cycle read latency.
   always @(posedge clk) begin
      if (mem_req) begin
         if (mem_we) begin
            for (int b = 0; b < 4; b++)
               if (mem_be[b]) bmem[mem_addr + 32'(b)] = mem_wdata[8*b +: 8];
         end else begin
            mem_rdata <= bmem_word(mem_addr);
         end
      end
   end

   function automatic logic [7:0] ref_byte(input logic [31:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
   endfunction

   function automatic int size_of(input logic [2:0] c);
      case (c)
         3'b000, 3'b100: return 1;
         3'b001, 3'b101: return 2;
         3'b010:         return 4;
         default:        return 0;
      endcase
   endfunction

   function automatic bit legal_of(input logic we, input logic [2:0] c);
      if (c == 3'b000 || c == 3'b001 || c == 3'b010) return 1'b1;
      if (c == 3'b100 || c == 3'b101) return !we;
      return 1'b0;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s/%s: got %h expected %h", cur_name, tag, obs, exp);
      end
   endtask

   task automatic preload(input logic [31:0] a, input logic [31:0] w);
      for (int b = 0; b < 4; b++) begin
         bmem[a + 32'(b)]    = w[8*b +: 8];
         ref_mem[a + 32'(b)] = w[8*b +: 8];
      end
   endtask

   // Issue one request from a negedge and check every cycle until the response.
   task automatic do_req(input string name, input logic we, input logic [2:0] ctrl,
                         input logic [31:0] addr, input logic [31:0] wd);
      int          sz, off, exp_n, exp_lat, n_acc, lat, cyc, j;
      bit          lg, got;
      logic [31:0] e_addr [2];
      logic [3:0]  e_be   [2];
      logic [31:0] e_wd   [2];
      logic [31:0] a_addr [2];
      logic [3:0]  a_be   [2];
      logic [31:0] a_wd   [2];
      int          a_cyc  [2];
      logic [31:0] exp_r, got_r;
      logic        got_e;

      cur_name = name;
      sz  = size_of(ctrl);
      lg  = legal_of(we, ctrl);
      off = int'(addr[1:0]);
      exp_n = !lg ? 0 : ((off + sz > 4) ? 2 : 1);
      exp_lat = !lg ? 2 : ((exp_n == 2) ? 4 : 3);
      for (int k = 0; k < 2; k++) begin
         e_addr[k] = {addr[31:2], 2'b00} + 32'(4 * k);
         e_be[k] = '0;
         e_wd[k] = '0;
         for (int b = 0; b < 4; b++) begin
            j = 4 * k + b - off;
            if (j >= 0 && j < sz) begin
               e_be[k][b] = 1'b1;
               e_wd[k][8*b +: 8] = wd[8*j +: 8];
            end
         end
      end
      exp_r = '0;
      if (lg && !we) begin
         for (int i = 0; i < sz; i++) exp_r[8*i +: 8] = ref_byte(addr + 32'(i));
         if (ctrl == 3'b000 && exp_r[7])  exp_r[31:8]  = '1;
         if (ctrl == 3'b001 && exp_r[15]) exp_r[31:16] = '1;
      end

      chk("ready_before", {31'd0, req_ready}, 32'd1);
      req_valid = 1'b1;
      req_we    = we;
      req_ctrl  = ctrl;
      req_addr  = addr;
      req_wdata = wd;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      req_we    = 1'($urandom);
      req_ctrl  = 3'($urandom);
      req_addr  = $urandom;
      req_wdata = $urandom;

      n_acc = 0; lat = 0; got = 1'b0; got_r = 'x; got_e = 1'bx;
      for (int k = 0; k < 2; k++) begin
         a_addr[k] = 'x; a_be[k] = 'x; a_wd[k] = 'x; a_cyc[k] = 0;
      end
      cyc = 1;
      while (!got && cyc <= 8) begin
         if (mem_req) begin
            if (n_acc < 2) begin
               a_addr[n_acc] = mem_addr;
               a_be[n_acc]   = mem_be;
               a_wd[n_acc]   = mem_wdata;
               a_cyc[n_acc]  = cyc;
            end
            n_acc++;
            chk("mem_we", {31'd0, mem_we}, {31'd0, we});
         end else begin
            chk("mem_idle_zero", {31'd0, mem_we} | {28'd0, mem_be} | mem_addr | mem_wdata, 32'd0);
         end
         if (rsp_valid) begin
            got = 1'b1; lat = cyc; got_r = rsp_rdata; got_e = rsp_err;
         end else begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
         end
      end

      chk("latency", 32'(lat), 32'(exp_lat));
      chk("n_access", 32'(n_acc), 32'(exp_n));
      for (int k = 0; k < exp_n; k++) begin
         if (k < n_acc) begin
            chk($sformatf("acc%0d_cycle", k), 32'(a_cyc[k]), 32'(k + 1));
            chk($sformatf("acc%0d_addr", k), a_addr[k], e_addr[k]);
            chk($sformatf("acc%0d_be", k), {28'd0, a_be[k]}, {28'd0, e_be[k]});
            if (we) chk($sformatf("acc%0d_wdata", k), a_wd[k], e_wd[k]);
         end
      end
      chk("rsp_err", {31'd0, got_e}, {31'd0, !lg});
      chk("rsp_rdata", got_r, exp_r);

      @(posedge clk);
      @(negedge clk);
      chk("rsp_pulse_end", {31'd0, rsp_valid}, 32'd0);
      chk("ready_after", {31'd0, req_ready}, 32'd1);
      chk("rdata_hold", rsp_rdata, exp_r);

      if (lg && we)
         for (int i = 0; i < sz; i++) ref_mem[addr + 32'(i)] = wd[8*i +: 8];
   endtask

   initial begin
      logic [31:0] base, ra;
      logic [2:0]  rc;
      logic        rw;

      rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0;
      req_ctrl = '0; req_addr = '0; req_wdata = '0;
      preload(32'h100, 32'hAABBCCDD);
      preload(32'h104, 32'h11223344);

      repeat (2) @(negedge clk);
      cur_name = "reset";
      chk("req_ready", {31'd0, req_ready}, 32'd1);
      chk("rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rsp_rdata", rsp_rdata, 32'd0);
      chk("rsp_err",   {31'd0, rsp_err}, 32'd0);
      chk("mem_req",   {31'd0, mem_req}, 32'd0);
      chk("mem_zero",  {31'd0, mem_we} | {28'd0, mem_be} | mem_addr | mem_wdata, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      do_req("lw_100",  1'b0, 3'b010, 32'h100, 32'h0);
      do_req("lb_103",  1'b0, 3'b000, 32'h103, 32'h0);
      do_req("lbu_103", 1'b0, 3'b100, 32'h103, 32'h0);
      do_req("lh_103",  1'b0, 3'b001, 32'h103, 32'h0);
      do_req("lw_102",  1'b0, 3'b010, 32'h102, 32'h0);
      do_req("sw_101",  1'b1, 3'b010, 32'h101, 32'h12345678);
      do_req("lw_101",  1'b0, 3'b010, 32'h101, 32'h0);
      do_req("lhu_106", 1'b0, 3'b101, 32'h106, 32'h0);
      do_req("sb_107",  1'b1, 3'b000, 32'h107, 32'hFFFFFF85);
      do_req("lb_107",  1'b0, 3'b000, 32'h107, 32'h0);
      do_req("ctrl_011", 1'b0, 3'b011, 32'h100, 32'h0);
      do_req("sbu_ill", 1'b1, 3'b100, 32'h100, 32'hDEADBEEF);
      do_req("sh_wrap", 1'b1, 3'b001, 32'hFFFFFFFF, 32'h0000BEEF);
      do_req("lh_wrap", 1'b0, 3'b001, 32'hFFFFFFFF, 32'h0);

      // Reset during the second access of a split load.
      cur_name = "reset_mid";
      req_valid = 1'b1; req_we = 1'b0; req_ctrl = 3'b001; req_addr = 32'h103;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      @(posedge clk);
      #1;
      chk("issue1_req", {31'd0, mem_req}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("mem_req_drop", {31'd0, mem_req}, 32'd0);
      chk("mem_zero", {31'd0, mem_we} | {28'd0, mem_be} | mem_addr | mem_wdata, 32'd0);
      chk("ready_in_rst", {31'd0, req_ready}, 32'd1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("no_rsp", {31'd0, rsp_valid}, 32'd0);
         chk("no_mem", {31'd0, mem_req}, 32'd0);
         chk("ready_rel", {31'd0, req_ready}, 32'd1);
      end

      for (int n = 0; n < 60; n++) begin
         base = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFF0 : 32'h100;
         ra = base + 32'($urandom_range(0, 31));
         rc = 3'($urandom_range(0, 7));
         rw = 1'($urandom);
         do_req($sformatf("rnd%0d", n), rw, rc, ra, $urandom);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
